seven_seg_to_hex_monitor: RTL

//  Inverse of the hex-to-7-segment encoding: watches N_DIGITS active-low 7-segment

---
 rtl/seven_seg_to_hex_monitor.sv | 134 +++++++++++++
 1 files changed

// File: rtl/seven_seg_to_hex_monitor.sv
// Watches N_DIGITS active-low 7-segment buses, debounces each digit and decodes the committed pattern.
// Optional SEVEN_SEG_MONITOR_STICKY_ERR_EN: o_error latches until reset.
module seven_seg_to_hex_monitor #(
  parameter int N_DIGITS      = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7*N_DIGITS-1:0] i_display,
  output logic [4*N_DIGITS-1:0] o_value,
  output logic [N_DIGITS-1:0]   o_valid,
  output logic [N_DIGITS-1:0]   o_blank,
  output logic [N_DIGITS-1:0]   o_error,
  output logic                  o_update
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_COMMIT = CW'(STABLE_CYCLES - 1);
  localparam logic [6:0]    BLANK_PAT  = 7'h7F;

  // Returns {legal, nibble}.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'h40:   r = 5'h10;
      7'h79:   r = 5'h11;
      7'h24:   r = 5'h12;
      7'h30:   r = 5'h13;
      7'h19:   r = 5'h14;
      7'h12:   r = 5'h15;
      7'h02:   r = 5'h16;
      7'h78:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h18:   r = 5'h19;
      7'h08:   r = 5'h1A;
      7'h03:   r = 5'h1B;
      7'h46:   r = 5'h1C;
      7'h21:   r = 5'h1D;
      7'h06:   r = 5'h1E;
      7'h0E:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [N_DIGITS-1:0][6:0]    sample_q, sample_d;
  logic [N_DIGITS-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N_DIGITS-1:0][6:0]    commit_q, commit_d;
  logic [N_DIGITS-1:0]         seen_q, seen_d;
  logic [N_DIGITS-1:0][3:0]    value_q, value_d;
  logic [N_DIGITS-1:0]         valid_q, valid_d;
  logic [N_DIGITS-1:0]         blank_q, blank_d;
  logic [N_DIGITS-1:0]         error_q, error_d;
  logic                        update_q, update_d;

  logic [6:0] new_pat;
  logic [4:0] dec;
  logic       is_blank;
  logic       is_illegal;

  always_comb begin
    sample_d   = sample_q;
    cnt_d      = cnt_q;
    commit_d   = commit_q;
    seen_d     = seen_q;
    value_d    = value_q;
    valid_d    = valid_q;
    blank_d    = blank_q;
    error_d    = error_q;
    update_d   = 1'b0;
    new_pat    = '0;
    dec        = '0;
    is_blank   = 1'b0;
    is_illegal = 1'b0;
    for (int d = 0; d < N_DIGITS; d++) begin
      new_pat     = i_display[7*d +: 7];
      sample_d[d] = new_pat;
      if (new_pat != sample_q[d]) begin
        cnt_d[d] = '0;
      end else if (cnt_q[d] != CNT_MAX) begin
        cnt_d[d] = cnt_q[d] + 1'b1;
      end
      // The incoming sample matching a counter at STABLE_CYCLES-1 is the commit point.
      if (new_pat == sample_q[d] && cnt_q[d] == CNT_COMMIT) begin
        dec        = decode(sample_q[d]);
        is_blank   = (sample_q[d] == BLANK_PAT);
        is_illegal = !dec[4] && !is_blank;
        valid_d[d] = dec[4];
        blank_d[d] = is_blank;
        if (dec[4]) value_d[d] = dec[3:0];
`ifdef SEVEN_SEG_MONITOR_STICKY_ERR_EN
        error_d[d] = error_q[d] | is_illegal;
`else
        error_d[d] = is_illegal;
`endif
        if (!seen_q[d] || commit_q[d] != sample_q[d]) update_d = 1'b1;
        commit_d[d] = sample_q[d];
        seen_d[d]   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sample_q <= {N_DIGITS{BLANK_PAT}};
      cnt_q    <= '0;
      commit_q <= '0;
      seen_q   <= '0;
      value_q  <= '0;
      valid_q  <= '0;
      blank_q  <= '0;
      error_q  <= '0;
      update_q <= 1'b0;
    end else begin
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      commit_q <= commit_d;
      seen_q   <= seen_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      blank_q  <= blank_d;
      error_q  <= error_d;
      update_q <= update_d;
    end
  end

  assign o_value  = value_q;
  assign o_valid  = valid_q;
  assign o_blank  = blank_q;
  assign o_error  = error_q;
  assign o_update = update_q;

endmodule
